id_ex_stage_reg: RTL and testbench

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

---
 rtl/arm_pkg.sv | 45 ++++
 rtl/id_ex_stage_reg_pipe_reg.sv | 25 ++
 rtl/id_ex_stage_reg.sv | 129 ++++++++++++
 tb/tb_id_ex_stage_reg.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM pipeline widths, ALU command encoding and ID/EX control payload.
package arm_pkg;

    localparam int unsigned REG_IDX_W  = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SHIFT_OP_W = 12;
    localparam int unsigned IMM24_W    = 24;
    localparam int unsigned EXE_CMD_W  = 4;

    typedef logic [EXE_CMD_W-1:0] exe_cmd_t;

    localparam exe_cmd_t EXE_NOP = 4'b0000;
    localparam exe_cmd_t EXE_MOV = 4'b0001;
    localparam exe_cmd_t EXE_ADD = 4'b0010;
    localparam exe_cmd_t EXE_ADC = 4'b0011;
    localparam exe_cmd_t EXE_SUB = 4'b0100;
    localparam exe_cmd_t EXE_SBC = 4'b0101;
    localparam exe_cmd_t EXE_AND = 4'b0110;
    localparam exe_cmd_t EXE_ORR = 4'b0111;
    localparam exe_cmd_t EXE_EOR = 4'b1000;
    localparam exe_cmd_t EXE_MVN = 4'b1001;

    typedef struct packed {
        logic     wb_en;
        logic     mem_r_en;
        logic     mem_w_en;
        logic     b;
        logic     s;
        exe_cmd_t exe_cmd;
    } ctrl_t;

    typedef struct packed {
        logic                  imm;
        logic [SHIFT_OP_W-1:0] shift_operand;
        logic [IMM24_W-1:0]    signed_imm_24;
    } operand_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] src1;
        logic [REG_IDX_W-1:0] src2;
        logic                 use_src1;
        logic                 use_src2;
    } fwd_t;

endpackage

// File: rtl/id_ex_stage_reg_pipe_reg.sv
// Generic pipeline register: async clear, hold when en=0, synchronous clear to 0.
module pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            if (clr) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with freeze, flush and load-use bubble insertion.
// Define FORWARD_EN to register source indices/use flags for the forwarding unit.
module id_ex_stage_reg
    import arm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  bubble,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  exe_cmd_t              exe_cmd_in,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     rn_val_in,
    input  logic [DATA_W-1:0]     rm_val_in,
    input  logic                  imm_in,
    input  logic [SHIFT_OP_W-1:0] shift_operand_in,
    input  logic [IMM24_W-1:0]    signed_imm_24_in,
    input  logic [REG_IDX_W-1:0]  dest_in,
    input  logic                  carry_in,
    input  logic [REG_IDX_W-1:0]  src1_in,
    input  logic [REG_IDX_W-1:0]  src2_in,
    input  logic                  use_src1_in,
    input  logic                  use_src2_in,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic                  b_out,
    output logic                  s_out,
    output exe_cmd_t              exe_cmd_out,
    output logic [DATA_W-1:0]     pc_out,
    output logic [DATA_W-1:0]     rn_val_out,
    output logic [DATA_W-1:0]     rm_val_out,
    output logic                  imm_out,
    output logic [SHIFT_OP_W-1:0] shift_operand_out,
    output logic [IMM24_W-1:0]    signed_imm_24_out,
    output logic [REG_IDX_W-1:0]  dest_out,
    output logic                  carry_out,
    output logic [REG_IDX_W-1:0]  src1_out,
    output logic [REG_IDX_W-1:0]  src2_out,
    output logic                  use_src1_out,
    output logic                  use_src2_out,
    output logic                  valid_out
);

    localparam int unsigned CTRL_W = $bits(ctrl_t);
    localparam int unsigned OPND_W = $bits(operand_t);
    localparam int unsigned VALS_W = 2 * DATA_W;

    // Freeze outranks flush/bubble: a frozen slot ignores clr entirely.
    logic en;
    logic clr;
    assign en  = ~freeze;
    assign clr = flush | bubble;

    ctrl_t    ctrl_d, ctrl_q;
    operand_t opnd_d, opnd_q;

    assign ctrl_d = '{wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                      b: b_in, s: s_in, exe_cmd: exe_cmd_in};
    assign opnd_d = '{imm: imm_in, shift_operand: shift_operand_in,
                      signed_imm_24: signed_imm_24_in};

    pipe_reg #(.W(CTRL_W)) u_ctrl (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(ctrl_d), .q(ctrl_q)
    );

    pipe_reg #(.W(1)) u_valid (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(1'b1), .q(valid_out)
    );

    pipe_reg #(.W(DATA_W)) u_pc (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(pc_in), .q(pc_out)
    );

    pipe_reg #(.W(VALS_W)) u_vals (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .d({rn_val_in, rm_val_in}), .q({rn_val_out, rm_val_out})
    );

    pipe_reg #(.W(OPND_W)) u_opnd (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(opnd_d), .q(opnd_q)
    );

    pipe_reg #(.W(REG_IDX_W + 1)) u_dest (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .d({dest_in, carry_in}), .q({dest_out, carry_out})
    );

    assign wb_en_out         = ctrl_q.wb_en;
    assign mem_r_en_out      = ctrl_q.mem_r_en;
    assign mem_w_en_out      = ctrl_q.mem_w_en;
    assign b_out             = ctrl_q.b;
    assign s_out             = ctrl_q.s;
    assign exe_cmd_out       = ctrl_q.exe_cmd;
    assign imm_out           = opnd_q.imm;
    assign shift_operand_out = opnd_q.shift_operand;
    assign signed_imm_24_out = opnd_q.signed_imm_24;

`ifdef FORWARD_EN
    fwd_t fwd_d, fwd_q;

    assign fwd_d = '{src1: src1_in, src2: src2_in,
                     use_src1: use_src1_in, use_src2: use_src2_in};

    pipe_reg #(.W($bits(fwd_t))) u_fwd (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(fwd_d), .q(fwd_q)
    );

    assign src1_out     = fwd_q.src1;
    assign src2_out     = fwd_q.src2;
    assign use_src1_out = fwd_q.use_src1;
    assign use_src2_out = fwd_q.use_src2;
`else
    // No forwarding unit: source fields are tied off and their inputs ignored.
    logic unused_fwd;
    assign unused_fwd   = ^{src1_in, src2_in, use_src1_in, use_src2_in};

    assign src1_out     = '0;
    assign src2_out     = '0;
    assign use_src1_out = 1'b0;
    assign use_src2_out = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vector table, reset corners,
// and randomized traffic against a slot-level reference model.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [3:0]  exe_cmd;
        logic [31:0] pc;
        logic [31:0] rn_val;
        logic [31:0] rm_val;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic        carry;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        use_src1;
        logic        use_src2;
        logic        valid;
    } slot_t;

    typedef struct {
        logic  freeze;
        logic  flush;
        logic  bubble;
        slot_t in;
        slot_t exp;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  freeze, flush, bubble;
    slot_t din;
    slot_t dout;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
        .wb_en_in(din.wb_en), .mem_r_en_in(din.mem_r_en), .mem_w_en_in(din.mem_w_en),
        .b_in(din.b), .s_in(din.s), .exe_cmd_in(din.exe_cmd), .pc_in(din.pc),
        .rn_val_in(din.rn_val), .rm_val_in(din.rm_val), .imm_in(din.imm),
        .shift_operand_in(din.shift_operand), .signed_imm_24_in(din.signed_imm_24),
        .dest_in(din.dest), .carry_in(din.carry), .src1_in(din.src1), .src2_in(din.src2),
        .use_src1_in(din.use_src1), .use_src2_in(din.use_src2),
        .wb_en_out(dout.wb_en), .mem_r_en_out(dout.mem_r_en), .mem_w_en_out(dout.mem_w_en),
        .b_out(dout.b), .s_out(dout.s), .exe_cmd_out(dout.exe_cmd), .pc_out(dout.pc),
        .rn_val_out(dout.rn_val), .rm_val_out(dout.rm_val), .imm_out(dout.imm),
        .shift_operand_out(dout.shift_operand), .signed_imm_24_out(dout.signed_imm_24),
        .dest_out(dout.dest), .carry_out(dout.carry), .src1_out(dout.src1),
        .src2_out(dout.src2), .use_src1_out(dout.use_src1), .use_src2_out(dout.use_src2),
        .valid_out(dout.valid)
    );

    // What the slot holds after a normal load of instruction s.
    function automatic slot_t loaded(slot_t s);
        slot_t r = s;
        r.valid = 1'b1;
`ifndef FORWARD_EN
        r.src1     = 4'd0;
        r.src2     = 4'd0;
        r.use_src1 = 1'b0;
        r.use_src2 = 1'b0;
`endif
        return r;
    endfunction

    // Reference: freeze keeps the slot, flush/bubble empties it, otherwise it takes the new instruction.
    function automatic slot_t model_next(slot_t cur, slot_t in, logic frz, logic fl, logic bb);
        if (frz)      return cur;
        if (fl || bb) return '0;
        return loaded(in);
    endfunction

    function automatic slot_t rand_slot();
        slot_t s;
        s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return s;
    endfunction

    task automatic check(input string name, input slot_t act, input slot_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    vec_t  vecs[$];
    slot_t ia, ib, ic, id_, model;

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; bubble = 1'b0; din = '0;

        ia = '0; ia.pc = 32'h4; ia.rn_val = 32'h7; ia.exe_cmd = 4'b0010; ia.wb_en = 1'b1;
        ia.dest = 4'd3; ia.src1 = 4'd5; ia.use_src1 = 1'b1;
        ib = '0; ib.pc = 32'h8; ib.rm_val = 32'hDEAD_BEEF; ib.s = 1'b1; ib.carry = 1'b1;
        ib.shift_operand = 12'hABC; ib.src2 = 4'd9; ib.use_src2 = 1'b1;
        ic = '0; ic.pc = 32'hC; ic.mem_r_en = 1'b1; ic.wb_en = 1'b1; ic.imm = 1'b1;
        ic.signed_imm_24 = 24'h80_0001; ic.dest = 4'd12; ic.exe_cmd = 4'b0100;
        id_ = '0; id_.pc = 32'h10; id_.mem_w_en = 1'b1; id_.b = 1'b1; id_.rn_val = 32'h1234_5678;

        // {freeze, flush, bubble, inputs, slot expected after the edge}
        vecs.push_back('{1'b0, 1'b0, 1'b0, ia,  loaded(ia)});
        vecs.push_back('{1'b1, 1'b1, 1'b0, ib,  loaded(ia)});
        vecs.push_back('{1'b1, 1'b0, 1'b0, ib,  loaded(ia)});
        vecs.push_back('{1'b1, 1'b0, 1'b1, ib,  loaded(ia)});
        vecs.push_back('{1'b0, 1'b0, 1'b0, ib,  loaded(ib)});
        vecs.push_back('{1'b1, 1'b1, 1'b0, ic,  loaded(ib)});
        vecs.push_back('{1'b0, 1'b1, 1'b0, ic,  slot_t'('0)});
        vecs.push_back('{1'b0, 1'b0, 1'b1, ic,  slot_t'('0)});
        vecs.push_back('{1'b0, 1'b0, 1'b0, ic,  loaded(ic)});
        vecs.push_back('{1'b0, 1'b1, 1'b0, ia,  slot_t'('0)});
        vecs.push_back('{1'b0, 1'b1, 1'b1, ia,  slot_t'('0)});
        vecs.push_back('{1'b0, 1'b0, 1'b0, id_, loaded(id_)});

        #3;
        check("reset_state", dout, '0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            freeze = vecs[i].freeze; flush = vecs[i].flush; bubble = vecs[i].bubble;
            din = vecs[i].in;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), dout, vecs[i].exp);
        end

        // Spot checks on individual loaded fields
        check_bit("valid_loaded", dout.valid, 1'b1);
`ifdef FORWARD_EN
        din = ia; @(negedge clk); freeze = 1'b0; flush = 1'b0; bubble = 1'b0;
        @(posedge clk); #1;
        check_bit("use_src1_fwd", dout.use_src1, 1'b1);
        check_bit("src1_fwd_b0", dout.src1[0], 1'b1);
        check_bit("src1_fwd_b2", dout.src1[2], 1'b1);
`else
        din = ia; @(negedge clk); freeze = 1'b0; flush = 1'b0; bubble = 1'b0;
        @(posedge clk); #1;
        check_bit("use_src1_nofwd", dout.use_src1, 1'b0);
        check_bit("src1_nofwd_b0", dout.src1[0], 1'b0);
        check_bit("src1_nofwd_b2", dout.src1[2], 1'b0);
`endif

        // Asynchronous reset mid-cycle with a valid instruction at pc 0x10
        @(negedge clk); din = id_;
        @(posedge clk); #1;
        check("pre_reset_load", dout, loaded(id_));
        #2 rst = 1'b1;
        #1;
        check("async_reset", dout, '0);
        @(negedge clk); rst = 1'b0;

        // Reset during freeze still clears; first unfrozen edge after release loads
        @(negedge clk); din = ib; freeze = 1'b0;
        @(posedge clk); #1;
        check("load_before_frz_rst", dout, loaded(ib));
        @(negedge clk); freeze = 1'b1; din = ic;
        #1 rst = 1'b1;
        #1;
        check("reset_in_freeze", dout, '0);
        @(posedge clk); #1;
        check("reset_held_frozen", dout, '0);
        @(negedge clk); rst = 1'b0; freeze = 1'b0;
        @(posedge clk); #1;
        check("load_after_reset", dout, loaded(ic));

        // Randomized traffic, also confirming inputs never leak through before the edge
        model = loaded(ic);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            freeze = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 4) == 0);
            bubble = ($urandom_range(0, 4) == 0);
            din    = rand_slot();
            #1;
            check($sformatf("rand_hold%0d", n), dout, model);
            @(posedge clk);
            model = model_next(model, din, freeze, flush, bubble);
            #1;
            check($sformatf("rand%0d", n), dout, model);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
